// File: rtl/axis_ofmaps_unload.sv
`default_nettype none
// ============================================================================
// axis_ofmaps_unload: buffers 5-bit MAC result vectors and packs 6 lanes/beat
// onto an AXI-Stream master. Define OFMAPS_UNLOAD_TLAST_EN to drive tlast.
// Revision: 1.0
// ============================================================================
module axis_ofmaps_unload #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int MAC_NUM              = 256,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [5*MAC_NUM-1:0]            ofmaps_in,
  input  logic                            ofmaps_write,
  input  logic [11:0]                     output_channel_size,
  output logic                            fifo_full,
  output logic                            fifo_empty,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int VEC_W = 5 * MAC_NUM;

  logic [VEC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [8:0]       offset_q, offset_d;

  logic             w_push;
  logic             w_pop;
  logic             w_hs;
  logic             w_final;
  logic [12:0]      w_size_eff;
  logic [12:0]      w_lane;
  logic [29:0]      w_beat;
  logic [VEC_W-1:0] w_head;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Zero or oversize channel counts fall back to a full vector.
  assign w_size_eff = ((output_channel_size == 12'd0) ||
                       ({1'b0, output_channel_size} > 13'(MAC_NUM)))
                      ? 13'(MAC_NUM) : {1'b0, output_channel_size};

  assign w_head  = mem_q[rd_ptr_q];
  assign w_hs    = m_axis_tvalid & m_axis_tready;
  assign w_final = ({4'd0, offset_q} + 13'd6) >= w_size_eff;
  assign w_push  = ofmaps_write & ~fifo_full;
  assign w_pop   = w_hs & w_final;

  always_comb begin
    w_beat = '0;
    w_lane = '0;
    for (int j = 0; j < 6; j++) begin
      w_lane = {4'd0, offset_q} + 13'(j);
      if (w_lane < w_size_eff) begin
        w_beat[5*j +: 5] = w_head[5*w_lane +: 5];
      end
    end
  end

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    offset_d = offset_q;
    if (w_hs) begin
      offset_d = w_final ? 9'd0 : offset_q + 9'd6;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      offset_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      offset_q <= offset_d;
    end
  end

  // Storage needs no reset: a cleared count marks every entry invalid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= ofmaps_in;
    end
  end

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? C_M_AXIS_TDATA_WIDTH'({2'b00, w_beat}) : '0;

`ifdef OFMAPS_UNLOAD_TLAST_EN
  assign m_axis_tlast = m_axis_tvalid & w_final;
`else
  assign m_axis_tlast = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_ofmaps_unload.sv
`default_nettype none
// ============================================================================
// tb_axis_ofmaps_unload: scoreboard bench for axis_ofmaps_unload.
// Revision: 1.0
// ============================================================================
module tb_axis_ofmaps_unload;

  localparam int MAC_NUM    = 256;
  localparam int FIFO_DEPTH = 4;
  localparam int VEC_W      = 5 * MAC_NUM;
`ifdef OFMAPS_UNLOAD_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [VEC_W-1:0] ofmaps_in = '0;
  logic             ofmaps_write = 1'b0;
  logic [11:0]      output_channel_size = 12'd0;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b0;
  logic             m_axis_tlast;

  axis_ofmaps_unload #(
    .C_M_AXIS_TDATA_WIDTH(32),
    .MAC_NUM(MAC_NUM),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ofmaps_in(ofmaps_in),
    .ofmaps_write(ofmaps_write),
    .output_channel_size(output_channel_size),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard entry: {final-beat flag, packed data}
  logic [32:0] sb_q[$];
  int          model_cnt = 0;
  int          hs_cnt = 0;
  bit          mon_on = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_size(input logic [11:0] s);
    if (s == 12'd0 || int'(s) > MAC_NUM) return MAC_NUM;
    return int'(s);
  endfunction

  function automatic logic [31:0] exp_beat(input logic [VEC_W-1:0] v, input int n, input int b);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 6; j++) begin
      if (6*b + j < n) r[5*j +: 5] = v[5*(6*b + j) +: 5];
    end
    return r;
  endfunction

  // Monitor: compares the state produced by the last edge, then predicts the next edge.
  always @(negedge clk) begin
    bit          push_ok;
    bit          pop;
    int          n;
    int          nb;
    logic [32:0] e;
    if (mon_on) begin
      check("tvalid", m_axis_tvalid, model_cnt != 0);
      check("fifo_empty", fifo_empty, model_cnt == 0);
      check("fifo_full", fifo_full, model_cnt == FIFO_DEPTH);
      if (!m_axis_tvalid) begin
        check("idle_tdata", m_axis_tdata, 32'd0);
        check("idle_tlast", m_axis_tlast, 1'b0);
      end
      if (prev_stall && m_axis_tvalid) begin
        check("stall_tdata", m_axis_tdata, prev_data);
        check("stall_tlast", m_axis_tlast, prev_last);
      end
    end
    if (!rst_n) begin
      sb_q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
      mon_on     = 1'b1;
    end else if (mon_on) begin
      push_ok = ofmaps_write && (model_cnt < FIFO_DEPTH);
      pop     = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("beat_tdata", m_axis_tdata, e[31:0]);
          check("beat_tlast", m_axis_tlast, e[32] & TLAST_EN);
          pop = e[32];
        end
      end
      if (push_ok) begin
        n  = eff_size(output_channel_size);
        nb = (n + 5) / 6;
        for (int b = 0; b < nb; b++) sb_q.push_back({(b == nb - 1), exp_beat(ofmaps_in, n, b)});
      end
      model_cnt  = model_cnt + int'(push_ok) - int'(pop);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic push(input logic [VEC_W-1:0] v);
    ofmaps_in    = v;
    ofmaps_write = 1'b1;
    @(posedge clk);
    #1 ofmaps_write = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((model_cnt != 0 || m_axis_tvalid) && guard < 500) begin
      @(posedge clk);
      #1 guard++;
    end
    if (guard >= 500) check("drain_timeout", 1, 0);
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < MAC_NUM; i++) v[5*i +: 5] = 5'($urandom);
    return v;
  endfunction

  initial begin
    logic [VEC_W-1:0] v;
    int base;
    int guard;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_full", fifo_full, 1'b0);

    // Short vector, lane i = i % 32
    output_channel_size = 12'd12;
    m_axis_tready = 1'b1;
    for (int i = 0; i < MAC_NUM; i++) v[5*i +: 5] = 5'(i % 32);
    base = hs_cnt;
    push(v);
    check("short_valid_next", m_axis_tvalid, 1'b1);
    check("short_beat0", m_axis_tdata, 32'h0A418820);
    wait_drain();
    check("short_beats", hs_cnt - base, 2);
    check("short_empty", fifo_empty, 1'b1);

    // Full vector via size 0
    output_channel_size = 12'd0;
    base = hs_cnt;
    push(rand_vec());
    wait_drain();
    check("full_beats", hs_cnt - base, 43);

    // Backpressure during beat 2
    output_channel_size = 12'd30;
    base = hs_cnt;
    push(rand_vec());
    guard = 0;
    while (hs_cnt - base < 2 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 50) check("bp_timeout", 1, 0);
    #1 m_axis_tready = 1'b0;
    repeat (5) @(posedge clk);
    #1 m_axis_tready = 1'b1;
    wait_drain();
    check("bp_beats", hs_cnt - base, 5);

    // Overflow: five pushes into a four-deep FIFO
    output_channel_size = 12'd8;
    m_axis_tready = 1'b0;
    base = hs_cnt;
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < MAC_NUM; i++) v[5*i +: 5] = 5'(k);
      push(v);
      if (k == 3) check("ovf_not_full", fifo_full, 1'b0);
      if (k == 4) check("ovf_full", fifo_full, 1'b1);
    end
    check("ovf_still_full", fifo_full, 1'b1);
    m_axis_tready = 1'b1;
    wait_drain();
    check("ovf_beats", hs_cnt - base, 8);

    // Push coinciding with the final-beat handshake at count 2
    output_channel_size = 12'd12;
    m_axis_tready = 1'b0;
    base = hs_cnt;
    push(rand_vec());
    push(rand_vec());
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1 push(rand_vec());
    m_axis_tready = 1'b0;
    check("sim_not_full", fifo_full, 1'b0);
    push(rand_vec());
    check("sim_three", fifo_full, 1'b0);
    push(rand_vec());
    check("sim_four_full", fifo_full, 1'b1);
    m_axis_tready = 1'b1;
    wait_drain();
    check("sim_beats", hs_cnt - base, 10);

    // Reset in the middle of a vector
    output_channel_size = 12'd0;
    push(rand_vec());
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_tlast", m_axis_tlast, 1'b0);
    check("midrst_tdata", m_axis_tdata, 32'd0);
    check("midrst_empty", fifo_empty, 1'b1);
    repeat (5) @(posedge clk);
    #1 check("midrst_quiet", m_axis_tvalid, 1'b0);

    check("sb_leftover", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
